direction_controller: RTL and testbench

// Upstream of the per-frame position update stage. Turns debounced player

---
 rtl/direction_controller.sv | 152 +++++++++++++++
 tb/tb_direction_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/direction_controller.sv
`default_nettype none
// ============================================================================
// Module      : direction_controller
// Description : Turns debounced player buttons into the one-hot direction
//               consumed by the per-frame position update stage. A requested
//               turn is buffered for BUFFER_TICKS frames and committed only at
//               a tile-aligned position when legal_moves allows it. Reversals
//               commit at any position. A MOVING/BLOCKED state tracks wall
//               stops.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               frame_tick          - one-cycle pulse per frame; commits happen on it
//               btn[3:0]            - button levels [0]=left [1]=right [2]=up [3]=down
//               xpos, ypos [9:0]    - sprite position in pixels
//               legal_moves[3:0]    - per-direction legality, same bit order
//               curr_direction[3:0] - committed one-hot direction
//               queued_dir[3:0]     - pending request (one-hot or 0)
//               moving              - 1 = MOVING, 0 = BLOCKED
//               dir_changed         - pulse on the cycle after a direction change
// Revision    : 1.0 - initial release
// ============================================================================
module direction_controller #(
    parameter int unsigned TILE_BITS    = 3,
    parameter int unsigned BUFFER_TICKS = 16,
    parameter logic [3:0]  RESET_DIR    = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic [3:0] legal_moves,
    output logic [3:0] curr_direction,
    output logic [3:0] queued_dir,
    output logic       moving,
    output logic       dir_changed
);

    localparam logic [0:0] c_ST_BLOCKED = 1'b0;
    localparam logic [0:0] c_ST_MOVING  = 1'b1;
    localparam logic [7:0] c_AGE_LOAD   = 8'(BUFFER_TICKS);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [3:0] r_curr;
    logic [3:0] r_queued;
    logic [7:0] r_age;
    logic       r_dir_changed;

    logic [3:0] w_req;
    logic       w_btn_any;
    logic       w_capture;
    logic       w_cancel;
    logic       w_aligned;
    logic [3:0] w_opposite;
    logic       w_rev;
    logic       w_qlegal;
    logic       w_curr_legal;
    logic       w_take;
    logic [7:0] w_age_dec;

    // Upper position bits only matter to the position stage.
    logic w_unused_bits;
    assign w_unused_bits = ^{xpos[9:TILE_BITS], ypos[9:TILE_BITS]};

    // Priority encode: left > right > up > down.
    always_comb begin
        w_req = 4'b0000;
        if (btn[0])      w_req = 4'b0001;
        else if (btn[1]) w_req = 4'b0010;
        else if (btn[2]) w_req = 4'b0100;
        else if (btn[3]) w_req = 4'b1000;
    end

    assign w_btn_any    = |btn;
    assign w_capture    = w_btn_any && (w_req != r_curr);
    assign w_cancel     = w_btn_any && (w_req == r_curr);
    assign w_aligned    = (xpos[TILE_BITS-1:0] == '0) && (ypos[TILE_BITS-1:0] == '0);
    // Swap left<->right and up<->down.
    assign w_opposite   = {r_curr[2], r_curr[3], r_curr[0], r_curr[1]};
    assign w_rev        = (r_queued != 4'b0000) && (r_queued == w_opposite);
    assign w_qlegal     = |(r_queued & legal_moves);
    assign w_curr_legal = |(r_curr & legal_moves);
    assign w_age_dec    = r_age - 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_MOVING;
        else     r_state <= w_state_next;
    end

    // Next-state and commit decision
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        if (frame_tick) begin
            case (r_state)
                c_ST_MOVING: begin
                    if (w_rev && w_qlegal)              w_take = 1'b1;
                    else if (w_aligned && w_qlegal)     w_take = 1'b1;
                    else if (w_aligned && !w_curr_legal) w_state_next = c_ST_BLOCKED;
                end
                default: begin
                    if (w_qlegal) begin
                        w_take       = 1'b1;
                        w_state_next = c_ST_MOVING;
                    end else if (w_curr_legal) begin
                        w_state_next = c_ST_MOVING;
                    end
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        moving = (r_state == c_ST_MOVING);
    end

    // Direction, request buffer and age counter. A capture is applied last so
    // it wins over both the take's clear and ageing on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_curr        <= RESET_DIR;
            r_queued      <= 4'b0000;
            r_age         <= 8'd0;
            r_dir_changed <= 1'b0;
        end else begin
            r_dir_changed <= w_take;
            if (w_take) begin
                r_curr   <= r_queued;
                r_queued <= 4'b0000;
                r_age    <= 8'd0;
            end else if (frame_tick && (r_queued != 4'b0000)) begin
                r_age <= w_age_dec;
                if (w_age_dec == 8'd0) r_queued <= 4'b0000;
            end
            if (w_capture) begin
                r_queued <= w_req;
                r_age    <= c_AGE_LOAD;
            end else if (w_cancel) begin
                r_queued <= 4'b0000;
            end
        end
    end

    assign curr_direction = r_curr;
    assign queued_dir     = r_queued;
    assign dir_changed    = r_dir_changed;

endmodule
`default_nettype wire

// File: tb/tb_direction_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_direction_controller
// Description : Directed self-checking bench for direction_controller, built
//               with BUFFER_TICKS=4 so request expiry is short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direction_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [9:0] xpos = 10'd0;
    logic [9:0] ypos = 10'd0;
    logic [3:0] legal_moves = 4'b1111;
    logic [3:0] curr_direction;
    logic [3:0] queued_dir;
    logic       moving;
    logic       dir_changed;

    int n_tests = 0;
    int n_fail  = 0;

    direction_controller #(
        .TILE_BITS    (3),
        .BUFFER_TICKS (4),
        .RESET_DIR    (4'b0001)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .btn            (btn),
        .xpos           (xpos),
        .ypos           (ypos),
        .legal_moves    (legal_moves),
        .curr_direction (curr_direction),
        .queued_dir     (queued_dir),
        .moving         (moving),
        .dir_changed    (dir_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock; inputs then change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle frame tick with the current inputs.
    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Single-cycle button pulse.
    task automatic press(input logic [3:0] b);
        btn = b;
        step();
        btn = 4'b0000;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_curr",    curr_direction, 4'b0001);
        check("rst_moving",  {3'b0, moving}, 4'b0001);
        check("rst_queued",  queued_dir,     4'b0000);
        check("rst_changed", {3'b0, dir_changed}, 4'b0000);

        // Turn queue: down requested while unaligned, committed at x=8
        xpos = 10'd13; ypos = 10'd16; legal_moves = 4'b1111;
        press(4'b1000);
        check("q_queued", queued_dir,     4'b1000);
        check("q_curr",   curr_direction, 4'b0001);
        tick();
        check("q_unal_curr",   curr_direction, 4'b0001);
        check("q_unal_queued", queued_dir,     4'b1000);
        xpos = 10'd8;
        tick();
        check("q_take_curr",    curr_direction, 4'b1000);
        check("q_take_queued",  queued_dir,     4'b0000);
        check("q_take_changed", {3'b0, dir_changed}, 4'b0001);
        step();
        check("q_changed_drop", {3'b0, dir_changed}, 4'b0000);

        // Expiry: up (illegal here) ages out after 4 ticks
        xpos = 10'd13; legal_moves = 4'b1000;
        press(4'b0100);
        check("exp_queued", queued_dir, 4'b0100);
        tick(); tick(); tick();
        check("exp_tick3_queued", queued_dir, 4'b0100);
        tick();
        check("exp_tick4_queued", queued_dir,     4'b0000);
        check("exp_curr",         curr_direction, 4'b1000);
        check("exp_moving",       {3'b0, moving}, 4'b0001);

        // Reach right at an aligned tile
        xpos = 10'd8; legal_moves = 4'b1111;
        press(4'b0010);
        tick();
        check("to_right_curr", curr_direction, 4'b0010);

        // Reversal commits without alignment
        xpos = 10'd13; legal_moves = 4'b0011;
        press(4'b0001);
        check("rev_queued", queued_dir, 4'b0001);
        tick();
        check("rev_curr",   curr_direction, 4'b0001);
        check("rev_queued_clr", queued_dir, 4'b0000);

        // Wall: aligned, left illegal -> BLOCKED, then up escapes
        xpos = 10'd8; ypos = 10'd16; legal_moves = 4'b1100;
        tick();
        check("wall_moving", {3'b0, moving}, 4'b0000);
        check("wall_curr",   curr_direction, 4'b0001);
        press(4'b0100);
        tick();
        check("wall_esc_curr",   curr_direction, 4'b0100);
        check("wall_esc_moving", {3'b0, moving}, 4'b0001);
        check("wall_esc_queued", queued_dir,     4'b0000);

        // Collision: back to left, queue up, then capture down on the commit tick
        legal_moves = 4'b1111;
        press(4'b0001);
        tick();
        check("col_left", curr_direction, 4'b0001);
        press(4'b0100);
        btn = 4'b1000;
        frame_tick = 1'b1;
        step();
        btn = 4'b0000;
        frame_tick = 1'b0;
        check("col_curr",   curr_direction, 4'b0100);
        check("col_queued", queued_dir,     4'b1000);

        // Reset mid-queue
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_curr",    curr_direction, 4'b0001);
        check("rst2_queued",  queued_dir,     4'b0000);
        check("rst2_moving",  {3'b0, moving}, 4'b0001);
        check("rst2_changed", {3'b0, dir_changed}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
